// File: rtl/adc_ltc2308_avg_if.sv
// adc_ltc2308_avg_if
//   Stream bundle between the LTC2308 sample path, the averager and its
//   downstream consumer (sample FIFO / Avalon readout).
//   Input side : in_valid (1-cycle strobe), in_ch[2:0], in_data[11:0]
//   Output side: out_valid, out_ready, out_ch[2:0], out_data[11:0]
//   Modports:
//     master - sample producer / result consumer (drives inputs and out_ready)
//     slave  - the averager
interface adc_ltc2308_avg_if;
    logic        in_valid;
    logic [2:0]  in_ch;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_ch;
    logic [11:0] out_data;

    modport master (
        output in_valid, in_ch, in_data, out_ready,
        input  out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data, out_ready,
        output out_valid, out_ch, out_data
    );
endinterface

// File: rtl/adc_ltc2308_avg.sv
// adc_ltc2308_avg
//   Per-channel boxcar averager in the adc_clk domain. Accumulates 2^N
//   samples per enabled channel (N = clamped cfg_log2_avg, latched after
//   reset and on clear) and emits one channel-tagged 12-bit average per
//   completed block through a 2-deep valid/ready output buffer.
//   Optional feature macro: ADC_AVG_ROUND_EN (round-half-up with saturation
//   instead of truncation).
//   Ports:
//     adc_clk       block clock
//     adc_reset     asynchronous active-high reset
//     clear         synchronous clear of all datapath state, reloads N
//     cfg_log2_avg  requested N (clamped to MAX_LOG2_AVG)
//     cfg_ch_mask   per-channel averaging enable
//     bus           sample input / result output stream (slave side)
//     overflow      sticky: a completed result was dropped on a full buffer
module adc_ltc2308_avg #(
    parameter int unsigned MAX_LOG2_AVG = 8
) (
    input  logic                    adc_clk,
    input  logic                    adc_reset,
    input  logic                    clear,
    input  logic [3:0]              cfg_log2_avg,
    input  logic [7:0]              cfg_ch_mask,
    adc_ltc2308_avg_if.slave        bus,
    output logic                    overflow
);

    localparam int unsigned AW = 12 + MAX_LOG2_AVG;
    localparam int unsigned CW = MAX_LOG2_AVG + 1;

    // Active averaging depth
    logic [3:0]    n_q;
    logic          n_loaded_q;
    logic [3:0]    n_clamped;

    // Stage S1
    logic          s1_valid_q, s1_valid_d;
    logic [2:0]    s1_ch_q, s1_ch_d;
    logic [11:0]   s1_data_q, s1_data_d;

    // Per-channel accumulation state
    logic [AW-1:0] acc_q [0:7];
    logic [AW-1:0] acc_d [0:7];
    logic [CW-1:0] cnt_q [0:7];
    logic [CW-1:0] cnt_d [0:7];

    // Stage S2 combinational results
    logic [AW-1:0] s2_sum;
    logic [CW-1:0] s2_cnt_inc;
    logic          blk_done;
    logic [11:0]   s2_result;

    // Output buffer
    logic [14:0]   fifo_mem_q [0:1];
    logic [14:0]   fifo_mem_d [0:1];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;
    logic          ovf_q, ovf_d;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_push;

    assign n_clamped = (cfg_log2_avg > 4'(MAX_LOG2_AVG)) ? 4'(MAX_LOG2_AVG) : cfg_log2_avg;

    // N is loaded once after reset release and then only by clear.
    always_ff @(posedge adc_clk or posedge adc_reset) begin
        if (adc_reset) begin
            n_q        <= '0;
            n_loaded_q <= 1'b0;
        end else begin
            n_loaded_q <= 1'b1;
            if (clear || !n_loaded_q) begin
                n_q <= n_clamped;
            end
        end
    end

    // S1 capture: masked-off samples never enter the pipeline.
    always_comb begin
        s1_valid_d = bus.in_valid && cfg_ch_mask[bus.in_ch] && !clear;
        s1_ch_d    = bus.in_ch;
        s1_data_d  = bus.in_data;
    end

    // S2: the only writer of acc/cnt, so back-to-back samples on one
    // channel always see the value written the previous cycle.
    always_comb begin
        s2_sum     = acc_q[s1_ch_q] + AW'(s1_data_q);
        s2_cnt_inc = cnt_q[s1_ch_q] + CW'(1);
        blk_done   = s1_valid_q && !clear && (s2_cnt_inc == (CW'(1) << n_q));
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        if (clear) begin
            for (int unsigned c = 0; c < 8; c++) begin
                acc_d[c] = '0;
                cnt_d[c] = '0;
            end
        end else if (s1_valid_q) begin
            if (blk_done) begin
                acc_d[s1_ch_q] = '0;
                cnt_d[s1_ch_q] = '0;
            end else begin
                acc_d[s1_ch_q] = s2_sum;
                cnt_d[s1_ch_q] = s2_cnt_inc;
            end
        end
    end

`ifdef ADC_AVG_ROUND_EN
    logic [AW:0] rnd_sum;
    logic [AW:0] rnd_shift;

    // One extra bit holds the rounding carry before saturation.
    always_comb begin
        rnd_sum = {1'b0, s2_sum};
        if (n_q != '0) begin
            rnd_sum = rnd_sum + ((AW+1)'(1) << (n_q - 4'd1));
        end
        rnd_shift = rnd_sum >> n_q;
        s2_result = (rnd_shift > (AW+1)'(4095)) ? 12'hFFF : rnd_shift[11:0];
    end
`else
    assign s2_result = 12'(s2_sum >> n_q);
`endif

    // Output buffer. On a simultaneous push and pop while full, the write
    // lands in the slot being popped this cycle, which is safe because the
    // head is read combinationally before the edge.
    always_comb begin
        fifo_pop   = (fifo_cnt_q != 2'd0) && bus.out_ready;
        fifo_full  = (fifo_cnt_q == 2'd2);
        fifo_push  = blk_done && (!fifo_full || fifo_pop);
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        ovf_d      = ovf_q;
        if (clear) begin
            fifo_mem_d[0] = '0;
            fifo_mem_d[1] = '0;
            wr_ptr_d      = 1'b0;
            rd_ptr_d      = 1'b0;
            fifo_cnt_d    = '0;
            ovf_d         = 1'b0;
        end else begin
            if (fifo_push) begin
                fifo_mem_d[wr_ptr_q] = {s1_ch_q, s2_result};
                wr_ptr_d             = ~wr_ptr_q;
            end
            if (fifo_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
            if (blk_done && fifo_full && !fifo_pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge adc_clk or posedge adc_reset) begin
        if (adc_reset) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_data_q  <= '0;
            for (int unsigned c = 0; c < 8; c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= '0;
            ovf_q         <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ch_q    <= s1_ch_d;
            s1_data_q  <= s1_data_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.out_valid = (fifo_cnt_q != 2'd0);
    assign bus.out_ch    = fifo_mem_q[rd_ptr_q][14:12];
    assign bus.out_data  = fifo_mem_q[rd_ptr_q][11:0];
    assign overflow      = ovf_q;

endmodule
